ram_responder: RTL and testbench
================================

# ram_responder

Word-addressed backing-store model and responder for the external-RAM side of the cache blocks. It sits where the external RAM connects: it accepts the single-word read/write requests a cache issues on `ram_address`/`ram_rd`/`ram_wr`/`ram_data_wr`. It answers each one after a programmable latency with a one-cycle `ram_data_valid` pulse, so cache fill and writeback FSMs can be exercised and timed against realistic memory delay.

## Interface
- `ADDRESS_WIDTH`, 16: byte-address width; must equal the cache's `ADDRESS_WIDTH`.
- `MEM_DEPTH_WIDTH`, 10: log2 of storage depth in 32-bit words; must be ≤ `ADDRESS_WIDTH-2`.
- `READ_LATENCY`, 4: cycles from read acceptance to `ram_data_valid`; legal range 1..15.
- `WRITE_LATENCY`, 2: cycles from write acceptance to `ram_data_valid` (write ack); legal range 1..15.
- `clk`  in  1  sole clock; everything updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `ram_address`  in  ADDRESS_WIDTH  byte address; bits [1:0] ignored.
- `ram_rd`  in  1  read request, sampled with address.
- `ram_wr`  in  1  write request, sampled with address and data.
- `ram_data_wr`  in  32  write data (full word, no byte enables).
- `ram_data_rd`  out  32  read data; valid only while `ram_data_valid` is high.
- `ram_data_valid`  out  1  one-cycle completion pulse for both reads and writes.
- `busy`  out  1  a request is outstanding.
- `protocol_error`  out  1  sticky flag for an illegal request; cleared only by reset.

## Operation
- Word index is `ram_address[MEM_DEPTH_WIDTH+1:2]`. Higher address bits are ignored, so addresses alias modulo the depth.
- Storage is an array of 2^MEM_DEPTH_WIDTH 32-bit words. Contents are not reset; the bench preloads them hierarchically.
- FSM states:
  - IDLE: not busy.
  - WAIT: a down-counter is running.
  - RESPOND: `ram_data_valid`=1.
- Accept condition: state is IDLE or RESPOND, and exactly one of `ram_rd`/`ram_wr` is high.
- On read acceptance:
  - Latch the word index and load the counter with `READ_LATENCY-1`.
  - Go to WAIT, or straight to RESPOND if the latency is 1.
- On write acceptance:
  - Commit `ram_data_wr` to the array on that same edge.
  - Load the counter with `WRITE_LATENCY-1`; enter WAIT or RESPOND as for reads.
- WAIT: decrement the counter each cycle. When it is 0, enter RESPOND on the next edge.
- RESPOND: holds for exactly one cycle.
  - For a read, `ram_data_rd` = array[latched index], read at response time.
  - For a write, `ram_data_rd` = 0.
  - Next state is IDLE if nothing is accepted that cycle; otherwise the new request's WAIT or RESPOND (back-to-back issue allowed).
- `busy` = 1 in WAIT and RESPOND.
- Illegal request: sets `protocol_error` and has no other effect (no store, no response, no state change). It is either of:
  - `ram_rd` and `ram_wr` both high in any state.
  - Any request in WAIT.
- Request lines low while IDLE: no effect. Holding `ram_rd` high across the response cycle counts as a new request.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, counter 0, `ram_data_valid`=0, `ram_data_rd`=0, `busy`=0, `protocol_error`=0.
- Reset mid-request: the outstanding request is abandoned with no response. A write already committed stays in the array.
- Request sampled at edge N, latency L: `ram_data_valid` is high during cycle N+L, i.e. it rises after edge N+L-1 and falls after edge N+L.
- Back-to-back reads, L=4: responses 4 cycles apart. Requests are issued in the respond cycles, giving sustained throughput of 1 word per L cycles.
- Read-after-write to the same word returns the new data, even at write latency 1.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `ram_rd`=1 -> all outputs 0, no response follows.
- Read with preload: word 5 = 0xDEADBEEF, read addr 0x0014 at edge N, `READ_LATENCY`=4 -> `ram_data_valid`=1 only in cycle N+4, `ram_data_rd`=0xDEADBEEF; `busy` high in cycles N+1..N+4.
- Write then read: write 0x12345678 to 0x0040, ack 2 cycles later; issue a read of 0x0040 in the ack cycle -> data 0x12345678 returned 4 cycles later, `protocol_error`=0.
- Line fill: 4 back-to-back reads, 0x0100-0x010C, each issued in the previous respond cycle -> exactly 4 valid pulses at N+4, N+8, N+12, N+16 with the preloaded words in order.
- Illegal requests:
  - `ram_rd`=`ram_wr`=1 while IDLE -> `protocol_error`=1, no response.
  - A read in WAIT -> ignored; the original response still arrives on time.
- Aliasing: with `MEM_DEPTH_WIDTH`=10, write 0xA5A5A5A5 to 0x1004, read 0x0004 -> 0xA5A5A5A5.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: word-addressed backing store that answers single-word read/write
// requests after a fixed, per-direction latency with a one-cycle completion pulse.
module ram_responder #(
  parameter int unsigned ADDRESS_WIDTH   = 16,
  parameter int unsigned MEM_DEPTH_WIDTH = 10,
  parameter int unsigned READ_LATENCY    = 4,
  parameter int unsigned WRITE_LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] ram_address,
  input  logic                     ram_rd,
  input  logic                     ram_wr,
  input  logic [31:0]              ram_data_wr,
  output logic [31:0]              ram_data_rd,
  output logic                     ram_data_valid,
  output logic                     busy,
  output logic                     protocol_error
);

  localparam int unsigned Depth     = 2 ** MEM_DEPTH_WIDTH;
  localparam logic [3:0]  ReadLoad  = 4'(READ_LATENCY - 1);
  localparam logic [3:0]  WriteLoad = 4'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [MEM_DEPTH_WIDTH-1:0] idx_q, idx_d;
  logic                       is_wr_q, is_wr_d;
  logic [31:0]                data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       perr_q, perr_d;

  logic [31:0]                mem [Depth];

  logic [MEM_DEPTH_WIDTH-1:0] req_idx;
  logic                       any_req;
  logic                       both_req;
  logic                       can_accept;
  logic                       accept;
  logic                       illegal;
  logic                       wr_commit;
  logic [3:0]                 load_cnt;
  logic                       unused_addr_bits;

  // Only the word-index bits select storage; the rest alias.
  assign unused_addr_bits = ^ram_address;

  // Request decode: acceptance and protocol violations for this cycle.
  always_comb begin
    req_idx    = ram_address[MEM_DEPTH_WIDTH+1:2];
    any_req    = ram_rd | ram_wr;
    both_req   = ram_rd & ram_wr;
    can_accept = (state_q == StIdle) || (state_q == StRespond);
    accept     = can_accept && (ram_rd ^ ram_wr);
    illegal    = both_req || ((state_q == StWait) && any_req);
    wr_commit  = accept && ram_wr;
    load_cnt   = ram_wr ? WriteLoad : ReadLoad;
  end

  // Next-state logic plus registered-output precompute.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    is_wr_d = is_wr_q;
    perr_d  = perr_q | illegal;

    unique case (state_q)
      StIdle, StRespond: begin
        if (accept) begin
          idx_d   = req_idx;
          is_wr_d = ram_wr;
          cnt_d   = load_cnt;
          state_d = (load_cnt == 4'd0) ? StRespond : StWait;
        end else begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      end
      StWait: begin
        // The counter reaches zero on the same edge that enters RESPOND, so WAIT
        // lasts latency-1 cycles and the pulse lands exactly latency cycles out.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StRespond;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase

    busy_d  = (state_d != StIdle);
    valid_d = (state_d == StRespond);
    // Read data is fetched on the edge entering RESPOND; a write committed on an
    // earlier edge is already visible, which keeps read-after-write coherent.
    data_d  = (valid_d && !is_wr_d) ? mem[idx_d] : 32'h0;
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      is_wr_q <= 1'b0;
      data_q  <= 32'h0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      is_wr_q <= is_wr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
    end
  end

  // Storage: written on the acceptance edge, never cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && wr_commit) begin
      mem[req_idx] <= ram_data_wr;
    end
  end

  assign ram_data_rd    = data_q;
  assign ram_data_valid = valid_q;
  assign busy           = busy_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed vector table, hand sequences
// for multi-cycle corners, and randomized traffic against a deadline-based model.
module tb_ram_responder;

  localparam int RL    = 4;
  localparam int WL    = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        valid;
  logic        busy;
  logic        perr;

  int checks = 0;
  int errors = 0;

  ram_responder #(
    .ADDRESS_WIDTH  (16),
    .MEM_DEPTH_WIDTH(10),
    .READ_LATENCY   (RL),
    .WRITE_LATENCY  (WL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ram_address   (addr),
    .ram_rd        (rd),
    .ram_wr        (wr),
    .ram_data_wr   (wdata),
    .ram_data_rd   (rdata),
    .ram_data_valid(valid),
    .busy          (busy),
    .protocol_error(perr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        ev;
    logic        eb;
    logic [31:0] ed;
    logic        ep;
  } vec_t;

  vec_t vecs[14];

  // Reference model: outstanding request tracked by its absolute due edge.
  logic [31:0] m_mem [DEPTH];
  int          cyc = 0;
  bit          m_pend = 0;
  bit          m_wr = 0;
  int          m_idx = 0;
  int          m_due = 0;
  bit          m_perr = 0;

  task automatic tick(input logic r_n, input logic r, input logic w,
                      input logic [15:0] a, input logic [31:0] d);
    rst = r_n; rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic ev, input logic eb,
                          input logic [31:0] ed, input logic ep);
    chk({name, ".valid"}, {31'h0, valid}, {31'h0, ev});
    chk({name, ".busy"},  {31'h0, busy},  {31'h0, eb});
    chk({name, ".perr"},  {31'h0, perr},  {31'h0, ep});
    if (ev) chk({name, ".data"}, rdata, ed);
  endtask

  task automatic rand_step(input logic r_n, input logic r, input logic w,
                           input logic [15:0] a, input logic [31:0] d);
    bit resp_now, wait_now, acc, ev;
    int idx;
    logic [31:0] ed;
    idx = int'(a >> 2) % DEPTH;
    cyc++;
    if (!r_n) begin
      m_pend = 0;
      m_perr = 0;
    end else begin
      resp_now = m_pend && (m_due == cyc - 1);
      wait_now = m_pend && !resp_now;
      acc = !wait_now && (r ^ w);
      if ((r && w) || (wait_now && (r || w))) m_perr = 1;
      if (acc) begin
        m_pend = 1;
        m_wr   = w;
        m_idx  = idx;
        m_due  = cyc + (w ? WL : RL) - 1;
        if (w) m_mem[idx] = d;
      end else if (resp_now) begin
        m_pend = 0;
      end
    end
    tick(r_n, r, w, a, d);
    ev = m_pend && (m_due == cyc);
    ed = m_wr ? 32'h0 : m_mem[m_idx];
    chk_outs($sformatf("rand@%0d", cyc), ev, m_pend, ed, m_perr);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 16'h0014, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h0040, 32'h12345678, 1'b0, 1'b1, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 1'b0, 16'h0040, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b1, 32'h12345678, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 1'b1, 16'h0014, 32'h55555555, 1'b0, 1'b0, 32'h0,        1'b1};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};

    // Reset held with a read request pending: nothing may come out.
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 1'b0, 16'h0014, 32'h0);
      chk_outs($sformatf("reset%0d", i), 1'b0, 1'b0, 32'h0, 1'b0);
      chk("reset.data", rdata, 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
      chk_outs($sformatf("post_reset%0d", i), 1'b0, 1'b0, 32'h0, 1'b0);
    end

    dut.mem[5] <= 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) dut.mem[64 + k] <= 32'h11110000 + 32'(k * 7 + 3);
    #1;

    for (int i = 0; i < 14; i++) begin
      tick(1'b1, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eb, vecs[i].ed, vecs[i].ep);
    end

    // Line fill: each read issued in the previous response cycle.
    tick(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b1, 1'b0, 16'h0100 + 16'(k * 4), 32'h0);
      chk_outs($sformatf("fill%0d.issue", k), 1'b0, 1'b1, 32'h0, 1'b0);
      for (int j = 0; j < 2; j++) begin
        tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        chk_outs($sformatf("fill%0d.wait%0d", k, j), 1'b0, 1'b1, 32'h0, 1'b0);
      end
      tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
      chk_outs($sformatf("fill%0d.resp", k), 1'b1, 1'b1, 32'h11110000 + 32'(k * 7 + 3), 1'b0);
    end
    tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    chk_outs("fill.done", 1'b0, 1'b0, 32'h0, 1'b0);

    // A read during WAIT is flagged and ignored; the original response keeps its slot.
    tick(1'b1, 1'b1, 1'b0, 16'h0014, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 16'h0040, 32'h0);
    chk_outs("wait_rd.flag", 1'b0, 1'b1, 32'h0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    chk_outs("wait_rd.w2", 1'b0, 1'b1, 32'h0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    chk_outs("wait_rd.resp", 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
      chk_outs($sformatf("wait_rd.after%0d", i), 1'b0, 1'b0, 32'h0, 1'b1);
    end

    // Aliasing: 0x1004 and 0x0004 share word 1.
    tick(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    tick(1'b1, 1'b0, 1'b1, 16'h1004, 32'hA5A5A5A5);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    chk_outs("alias.ack", 1'b1, 1'b1, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 16'h0004, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    chk_outs("alias.resp", 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0);

    // Reset mid-write: no ack ever arrives, but the committed word persists.
    tick(1'b1, 1'b0, 1'b1, 16'h0008, 32'hCAFEF00D);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    chk_outs("midrst.rst", 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
      chk_outs($sformatf("midrst.idle%0d", i), 1'b0, 1'b0, 32'h0, 1'b0);
    end
    tick(1'b1, 1'b1, 1'b0, 16'h0008, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    chk_outs("midrst.readback", 1'b1, 1'b1, 32'hCAFEF00D, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2; i++) rand_step(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] v;
      v = $urandom;
      dut.mem[i] <= v;
      m_mem[i] = v;
    end
    #1;
    for (int i = 0; i < 3000; i++) begin
      logic        r_n, r, w;
      logic [15:0] a;
      int          op;
      r_n = ($urandom_range(0, 149) != 0);
      op  = int'($urandom_range(0, 99));
      r   = (op < 40) || (op >= 65 && op < 68);
      w   = (op >= 40 && op < 68);
      a   = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a[11:4] = 8'h0;
      rand_step(r_n, r, w, a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
